// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core among NREQ requesters.
// One permutation in flight; a watchdog turns a missing done into an error response.
module ascon_perm_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [5*NREQ-1:0]   req_rounds_i,
  input  logic [320*NREQ-1:0] req_state_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  input  logic [NREQ-1:0]     rsp_ready_i,
  output logic [319:0]        rsp_state_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic                perm_start_o,
  output logic [4:0]          perm_rounds_o,
  output logic [319:0]        perm_state_in_o,
  input  logic [319:0]        perm_state_out_i,
  input  logic                perm_done_i
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gid_q, gid_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [4:0]        rounds_q, rounds_d;
  logic [319:0]      pin_q, pin_d;
  logic [319:0]      rsp_state_q, rsp_state_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_vld;
  logic [IdxW-1:0]   grant_idx;
  int unsigned       cand;
  logic [4:0]        sel_rounds;
  logic [319:0]      sel_state;

  // Scan from the pointer, wrapping; the first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_q) + i) % NREQ;
      if (!grant_vld && req_valid_i[cand[IdxW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    sel_rounds = req_rounds_i[32'(grant_idx)*5 +: 5];
    sel_state  = req_state_i[32'(grant_idx)*320 +: 320];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    timer_d     = timer_q;
    rounds_d    = rounds_q;
    pin_d       = pin_q;
    rsp_state_d = rsp_state_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    perm_start_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          req_ready_o[grant_idx] = 1'b1;
          gid_d    = grant_idx;
          pin_d    = sel_state;
          // Zero and anything above 12 fall back to the full 12-round permutation.
          rounds_d = ((sel_rounds == 5'd0) || (sel_rounds > 5'd12)) ? 5'd12 : sel_rounds;
          ptr_d    = IdxW'((32'(grant_idx) + 1) % NREQ);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        perm_start_o = 1'b1;
        timer_d      = '0;
        state_d      = StWait;
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        if (perm_done_i) begin
          rsp_state_d = perm_state_out_i;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          rsp_state_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        rsp_valid_o[gid_q] = 1'b1;
        if (rsp_ready_i[gid_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gid_q       <= '0;
      timer_q     <= '0;
      rounds_q    <= '0;
      pin_q       <= '0;
      rsp_state_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      timer_q     <= timer_d;
      rounds_q    <= rounds_d;
      pin_q       <= pin_d;
      rsp_state_q <= rsp_state_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign perm_rounds_o   = rounds_q;
  assign perm_state_in_o = pin_q;
  assign rsp_state_o     = rsp_state_q;
  assign rsp_err_o       = rsp_err_q;

endmodule
